// File: rtl/messbauer_discr_pkg.sv
// -----------------------------------------------------------------------------
// messbauer_discr_pkg
// Shared definitions for the differential discriminator receive path:
//   - discr_state_t : pulse-classifier FSM state encoding
//   - GEN_*         : pulse-shape constants of the discriminator test generator
//   - sat_inc()     : saturating increment used by the per-channel counters
// -----------------------------------------------------------------------------
package messbauer_discr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOWER_HIGH = 2'd1,
    ST_UPPER_SEEN = 2'd2,
    ST_STUCK      = 2'd3
  } discr_state_t;

  // Generator pulse shape: lower high for GEN_LOWER_CYCLES, optional upper
  // excursion starting GEN_UPPER_OFFSET cycles in, then a quiet gap.
  localparam int GEN_LOWER_CYCLES = 3;
  localparam int GEN_UPPER_OFFSET = 1;
  localparam int GEN_UPPER_CYCLES = 1;
  localparam int GEN_GAP_CYCLES   = 10;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/messbauer_diff_discriminator_counter_if.sv
// -----------------------------------------------------------------------------
// messbauer_diff_discriminator_counter_if
// Bundle between the discriminator (master) and the counter (slave).
//   master drives : lower_threshold, upper_threshold, channel
//   slave drives  : selected_count, rejected_count, channel_index,
//                   count_valid, sweep_done, protocol_error
// -----------------------------------------------------------------------------
interface messbauer_diff_discriminator_counter_if #(
  parameter int COUNT_WIDTH   = 16,
  parameter int CHANNEL_WIDTH = 10
);

  logic                     lower_threshold;
  logic                     upper_threshold;
  logic                     channel;
  logic [COUNT_WIDTH-1:0]   selected_count;
  logic [COUNT_WIDTH-1:0]   rejected_count;
  logic [CHANNEL_WIDTH-1:0] channel_index;
  logic                     count_valid;
  logic                     sweep_done;
  logic                     protocol_error;

  modport master (
    output lower_threshold, upper_threshold, channel,
    input  selected_count, rejected_count, channel_index,
    input  count_valid, sweep_done, protocol_error
  );

  modport slave (
    input  lower_threshold, upper_threshold, channel,
    output selected_count, rejected_count, channel_index,
    output count_valid, sweep_done, protocol_error
  );

endinterface

// File: rtl/messbauer_edge_sync.sv
// -----------------------------------------------------------------------------
// messbauer_edge_sync
// One discriminator input: optional 2-flop synchronizer (MESSBAUER_DISCR_SYNC_EN),
// then the single input register and a delayed copy for edge detection.
//   aclk, areset : clock, synchronous active-high reset
//   i_d          : raw input
//   o_level      : registered input level
//   o_rise/o_fall: one-cycle edge flags of o_level
// -----------------------------------------------------------------------------
module messbauer_edge_sync (
  input  logic aclk,
  input  logic areset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic w_d;

`ifdef MESSBAUER_DISCR_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge aclk) begin
    if (areset) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_d};
  end

  assign w_d = r_sync[1];
`else
  assign w_d = i_d;
`endif

  logic r_q;
  logic r_q_prev;

  // NOTE: clocked state uses <= so every flop samples pre-edge values;
  // blocking here would let r_q_prev see the new r_q and hide every edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_q      <= 1'b0;
      r_q_prev <= 1'b0;
    end else begin
      r_q      <= w_d;
      r_q_prev <= r_q;
    end
  end

  assign o_level = r_q;
  assign o_rise  = r_q & ~r_q_prev;
  assign o_fall  = ~r_q & r_q_prev;

endmodule

// File: rtl/messbauer_diff_discriminator_counter.sv
// -----------------------------------------------------------------------------
// messbauer_diff_discriminator_counter
// Classifies discriminator pulses (lower-only = selected, lower+upper =
// rejected), accumulates both per spectrometer channel with saturation, and
// reports them on each channel-strobe rising edge.
//   aclk, areset : clock, synchronous active-high reset
//   bus (slave)  : threshold/channel inputs; counts, index, strobes, error flag
// Optional: define MESSBAUER_DISCR_SYNC_EN to add 2-flop input synchronizers.
// -----------------------------------------------------------------------------
module messbauer_diff_discriminator_counter
  import messbauer_discr_pkg::*;
#(
  parameter int COUNT_WIDTH     = 16,
  parameter int CHANNEL_WIDTH   = 10,
  parameter int CHANNELS        = 512,
  parameter int MIN_LOWER_WIDTH = 2,
  parameter int MAX_LOWER_WIDTH = 64
) (
  input  logic aclk,
  input  logic areset,
  messbauer_diff_discriminator_counter_if.slave bus
);

  localparam int                     WIDTH_BITS   = $clog2(MAX_LOWER_WIDTH + 1);
  localparam logic [WIDTH_BITS-1:0]  MIN_W        = WIDTH_BITS'(MIN_LOWER_WIDTH);
  localparam logic [WIDTH_BITS-1:0]  MAX_W        = WIDTH_BITS'(MAX_LOWER_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CHANNEL = CHANNEL_WIDTH'(CHANNELS - 1);

  logic w_lt_level, w_lt_rise, w_lt_fall;
  logic w_ut_level, w_ut_rise, w_ut_fall;
  logic w_ch_level, w_ch_rise, w_ch_fall;

  messbauer_edge_sync u_lt_sync (.aclk(aclk), .areset(areset), .i_d(bus.lower_threshold),
                                 .o_level(w_lt_level), .o_rise(w_lt_rise), .o_fall(w_lt_fall));
  messbauer_edge_sync u_ut_sync (.aclk(aclk), .areset(areset), .i_d(bus.upper_threshold),
                                 .o_level(w_ut_level), .o_rise(w_ut_rise), .o_fall(w_ut_fall));
  messbauer_edge_sync u_ch_sync (.aclk(aclk), .areset(areset), .i_d(bus.channel),
                                 .o_level(w_ch_level), .o_rise(w_ch_rise), .o_fall(w_ch_fall));

  discr_state_t            r_state, w_state_next;
  logic [WIDTH_BITS-1:0]   r_width, w_width_next, w_width_inc;
  logic                    w_inc_sel, w_inc_rej, w_set_err;

  assign w_width_inc = r_width + WIDTH_BITS'(1);

  // NOTE: every output of this block is defaulted before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_width_next = r_width;
    w_inc_sel    = 1'b0;
    w_inc_rej    = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lt_rise) begin
          w_state_next = ST_LOWER_HIGH;
          w_width_next = WIDTH_BITS'(1);
        end else if (w_ut_rise && !w_lt_level) begin
          w_set_err = 1'b1;
        end
      end
      ST_LOWER_HIGH, ST_UPPER_SEEN: begin
        if (w_lt_fall) begin
          // First low sample closes the pulse; short ones are glitches.
          w_state_next = ST_IDLE;
          if (r_width >= MIN_W) begin
            if (r_state == ST_UPPER_SEEN || w_ut_level) w_inc_rej = 1'b1;
            else                                        w_inc_sel = 1'b1;
          end
        end else begin
          w_width_next = w_width_inc;
          if (w_width_inc >= MAX_W) begin
            w_state_next = ST_STUCK;
            w_set_err    = 1'b1;
          end else if (r_state == ST_LOWER_HIGH && w_ut_level) begin
            w_state_next = ST_UPPER_SEEN;
          end
        end
      end
      ST_STUCK: begin
        if (w_lt_fall) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic [COUNT_WIDTH-1:0]   r_sel, r_rej, w_sel_next, w_rej_next;
  logic [COUNT_WIDTH-1:0]   r_sel_out, r_rej_out;
  logic [CHANNEL_WIDTH-1:0] r_ptr, r_idx_out;
  logic                     r_valid, r_sweep, r_err;

  assign w_sel_next = w_inc_sel ? COUNT_WIDTH'(sat_inc(32'(r_sel), 32'(CNT_MAX))) : r_sel;
  assign w_rej_next = w_inc_rej ? COUNT_WIDTH'(sat_inc(32'(r_rej), 32'(CNT_MAX))) : r_rej;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_width   <= '0;
      r_sel     <= '0;
      r_rej     <= '0;
      r_ptr     <= '0;
      r_sel_out <= '0;
      r_rej_out <= '0;
      r_idx_out <= '0;
      r_valid   <= 1'b0;
      r_sweep   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_width <= w_width_next;
      r_valid <= w_ch_rise;
      r_sweep <= w_ch_rise && (r_ptr == LAST_CHANNEL);
      if (w_set_err) r_err <= 1'b1;
      if (w_ch_rise) begin
        // Report includes a classification landing on this same edge.
        r_sel_out <= w_sel_next;
        r_rej_out <= w_rej_next;
        r_idx_out <= r_ptr;
        r_sel     <= '0;
        r_rej     <= '0;
        r_ptr     <= (r_ptr == LAST_CHANNEL) ? '0 : r_ptr + CHANNEL_WIDTH'(1);
      end else begin
        r_sel <= w_sel_next;
        r_rej <= w_rej_next;
      end
    end
  end

  assign bus.selected_count = r_sel_out;
  assign bus.rejected_count = r_rej_out;
  assign bus.channel_index  = r_idx_out;
  assign bus.count_valid    = r_valid;
  assign bus.sweep_done     = r_sweep;
  assign bus.protocol_error = r_err;

endmodule

// File: doc/messbauer_diff_discriminator_counter.md
Name: messbauer_diff_discriminator_counter

Overview:
Receiving end of the differential discriminator interface. It samples the lower_threshold/upper_threshold pair produced by the detector discriminator (or its test-environment generator) and classifies each pulse. Lower-only pulses are "selected" (inside the window); pulses that also cross the upper threshold are "rejected". It accumulates both counts per spectrometer channel and reports them on each channel strobe, feeding the spectrum accumulator.

Parameters:
COUNT_WIDTH, 16, width of per-channel selected/rejected counters (saturating)
CHANNEL_WIDTH, 10, width of channel_index
CHANNELS, 512, channels per velocity sweep; index wraps at CHANNELS-1
MIN_LOWER_WIDTH, 2, minimum lower_threshold high time (aclk cycles) for a valid pulse
MAX_LOWER_WIDTH, 64, lower_threshold high time at which the pulse is declared stuck

Ports:
aclk  input  1  system clock
areset  input  1  synchronous reset, active high
lower_threshold  input  1  discriminator lower-level output
upper_threshold  input  1  discriminator upper-level output
channel  input  1  channel-advance strobe; rising edge closes the current channel
selected_count  output  COUNT_WIDTH  selected pulses of the closed channel
rejected_count  output  COUNT_WIDTH  rejected pulses of the closed channel
channel_index  output  CHANNEL_WIDTH  index of the closed channel
count_valid  output  1  one-cycle strobe qualifying the three outputs above
sweep_done  output  1  one-cycle strobe with count_valid when channel_index == CHANNELS-1
protocol_error  output  1  sticky flag; cleared only by reset

Behaviour:
- Interface: one clock, aclk. Reset is synchronous and active-high (areset).
- Reset: all outputs 0; internal counters, channel pointer and FSM cleared; state IDLE.
- Inputs are registered once (lt_d, ut_d, ch_d). Edges are detected against the registered copies.
- FSM states:
  - IDLE: lower sampled high -> LOWER_HIGH, width counter = 1. Upper rising while lower low -> set protocol_error, stay IDLE.
  - LOWER_HIGH: width +1 per cycle. Upper high -> UPPER_SEEN. Lower low -> CLASSIFY as selected. Width reaching MAX_LOWER_WIDTH -> STUCK, set protocol_error.
  - UPPER_SEEN: width keeps counting. Lower low -> CLASSIFY as rejected. Width reaching MAX_LOWER_WIDTH -> STUCK, set protocol_error.
  - STUCK: wait for lower low -> IDLE. No count.
- Classification happens on the edge where lower is first sampled low; the FSM returns to IDLE on that same edge.
  - Width < MIN_LOWER_WIDTH: pulse discarded as a glitch, no count.
  - Otherwise the selected or rejected counter increments, saturating at 2^COUNT_WIDTH-1.
- Lower rising again on the cycle right after a classification is accepted; back-to-back pulses are not lost.
- Channel strobe (rising edge of ch_d):
  - On the next edge, selected_count, rejected_count and channel_index are loaded from the internal counters and pointer, and count_valid pulses for one cycle.
  - Internal counters clear; the pointer increments, or wraps to 0 after CHANNELS-1 with sweep_done asserted.
  - A classification on the same cycle as the strobe is included in the closing channel's report.
  - An in-flight pulse (LOWER_HIGH/UPPER_SEEN) completes into the new channel.
- Outputs hold between strobes.
- Reset mid-pulse: FSM returns to IDLE. A lower signal still high after reset is treated as a new pulse start; a width below MIN is discarded normally.

Optional Feature:
MESSBAUER_DISCR_SYNC_EN
- Defined: lower_threshold, upper_threshold and channel each pass through a 2-flop synchronizer before the input register. All latencies grow by 2 cycles; relative timing between the signals is preserved.
- Undefined: inputs are synchronous to aclk; only the single input register is used.

Decomposition:
- Package messbauer_discr_pkg: FSM state encodings (IDLE, LOWER_HIGH, UPPER_SEEN, STUCK) and a shared saturating-increment function. The generator's phase constants also move to this package.
- One sub-module, messbauer_edge_sync: per-input synchronizer plus registered copy, with rise/fall outputs. Instantiated three times.

Test Plan:
- Lower high 3 cycles, upper low; then channel strobe -> count_valid with selected_count=1, rejected_count=0, channel_index=0.
- Lower high 3 cycles with upper high 1 cycle inside it, repeated 4 times; then strobe -> selected=0, rejected=4.
- Generator-style stream: 16 pulses, first 4 lower-only, 12 with upper, 10-cycle gaps; then strobe -> selected=4, rejected=12, protocol_error=0.
- Lower high 1 cycle (< MIN) -> no count. Lower held 64 cycles -> protocol_error=1, no count. Upper pulse with lower low -> protocol_error=1.
- Lower falls on the same cycle as the channel rising edge -> pulse counted in the reported channel (selected=1); the next channel starts at 0.
- 512 strobes -> sweep_done only with channel_index=511; next report has channel_index=0. 70000 pulses in one channel -> selected_count=65535.
